// File: rtl/des_mem_sequencer.sv
// DES block sequencer: streams num_blocks words from a source region of the block RAM
// through the DES core (valid/ready) and writes each result to a destination region.
module des_mem_sequencer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [ADDR_W:0]   num_blocks,
   output logic              busy,
   output logic              done,
   output logic              mem_ce0,
   output logic [ADDR_W-1:0] mem_addr0,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce1,
   output logic              mem_we1,
   output logic [ADDR_W-1:0] mem_addr1,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_in_valid,
   input  logic              core_in_ready,
   output logic [DATA_W-1:0] core_in_data,
   input  logic              core_out_valid,
   output logic              core_out_ready,
   input  logic [DATA_W-1:0] core_out_data
);

   localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ZERO_CNT = {(ADDR_W+1){1'b0}};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_REQ    = 3'd1,
      RD_DATA   = 3'd2,
      SEND      = 3'd3,
      CORE_WAIT = 3'd4,
      WR        = 3'd5,
      DONE      = 3'd6
   } state_t;

   state_t state_r, state_s;

   logic [ADDR_W-1:0] src_ptr_r, dst_ptr_r;
   logic [ADDR_W:0]   remaining_r;
   logic [DATA_W-1:0] blk_r, res_r;
   logic              launch_s;
   logic busy_s, done_s, ce0_s, wr_s, in_valid_s, out_ready_s;
   logic busy_r, done_r, ce0_r, wr_r, in_valid_r, out_ready_r;

   assign launch_s = (state_r == IDLE) && start && (num_blocks != ZERO_CNT);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:      if (launch_s) state_s = RD_REQ; else state_s = IDLE;
         RD_REQ:    state_s = RD_DATA;
         RD_DATA:   state_s = SEND;
         SEND:      if (core_in_ready) state_s = CORE_WAIT; else state_s = SEND;
         CORE_WAIT: if (core_out_valid) state_s = WR; else state_s = CORE_WAIT;
         WR:        if (remaining_r == ONE_CNT) state_s = DONE; else state_s = RD_REQ;
         DONE:      state_s = IDLE;
         default:   state_s = IDLE;
      endcase
   end

   // Control outputs decoded from the upcoming state so they can leave on flops
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      ce0_s       = 1'b0;
      wr_s        = 1'b0;
      in_valid_s  = 1'b0;
      out_ready_s = 1'b0;
      case (state_s)
         IDLE:      done_s = (state_r == IDLE) && start && (num_blocks == ZERO_CNT);
         RD_REQ:    begin busy_s = 1'b1; ce0_s = 1'b1; end
         RD_DATA:   busy_s = 1'b1;
         SEND:      begin busy_s = 1'b1; in_valid_s = 1'b1; end
         CORE_WAIT: begin busy_s = 1'b1; out_ready_s = 1'b1; end
         WR:        begin busy_s = 1'b1; wr_s = 1'b1; end
         DONE:      done_s = 1'b1;
         default:   done_s = 1'b0;
      endcase
   end

   // Output flops
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         ce0_r       <= 1'b0;
         wr_r        <= 1'b0;
         in_valid_r  <= 1'b0;
         out_ready_r <= 1'b0;
      end else begin
         busy_r      <= busy_s;
         done_r      <= done_s;
         ce0_r       <= ce0_s;
         wr_r        <= wr_s;
         in_valid_r  <= in_valid_s;
         out_ready_r <= out_ready_s;
      end
   end

   // Pointers, block counter and the block/result holding registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         src_ptr_r   <= {ADDR_W{1'b0}};
         dst_ptr_r   <= {ADDR_W{1'b0}};
         remaining_r <= ZERO_CNT;
         blk_r       <= {DATA_W{1'b0}};
         res_r       <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (launch_s) begin
                  src_ptr_r   <= src_base;
                  dst_ptr_r   <= dst_base;
                  remaining_r <= num_blocks;
               end
            end
            RD_DATA:   blk_r <= mem_rdata;
            CORE_WAIT: if (core_out_valid) res_r <= core_out_data;
            WR: begin
               // pointers wrap naturally at the top of the RAM
               src_ptr_r   <= src_ptr_r + ONE_ADDR;
               dst_ptr_r   <= dst_ptr_r + ONE_ADDR;
               remaining_r <= remaining_r - ONE_CNT;
            end
            default: ;
         endcase
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign mem_ce0        = ce0_r;
   assign mem_addr0      = src_ptr_r;
   assign mem_ce1        = wr_r;
   assign mem_we1        = wr_r;
   assign mem_addr1      = dst_ptr_r;
   assign mem_wdata      = res_r;
   assign core_in_valid  = in_valid_r;
   assign core_in_data   = blk_r;
   assign core_out_ready = out_ready_r;

endmodule
